not_arbiter: RTL

NOT_ARBITER -- requirements
Module: not_arbiter

---
 rtl/not_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/not_arbiter.sv
// Shared bitwise inverter with a round-robin front end. One request is granted
// per two cycles. The inverted data is returned one cycle after the grant, tagged with the owner's index.
module not_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N-1:0]                         req,
  input  logic [N*W-1:0]                       din,
  output logic [N-1:0]                         gnt,
  output logic                                 busy,
  output logic [W-1:0]                         y,
  output logic                                 y_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] y_id,
  output logic [15:0]                          gnt_cnt
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    data_q, data_d;
  logic [IW-1:0]   win_id_q, win_id_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [W-1:0]    y_q, y_d;
  logic            y_valid_q, y_valid_d;
  logic [IW-1:0]   y_id_q, y_id_d;
  logic [CW-1:0]   gnt_cnt_q, gnt_cnt_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [N-1:0]    win_oh;
  logic [W-1:0]    win_data;

  // Round-robin search: start at ptr_q, walk upward modulo N, first set req wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    win_data  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!win_found && req[idx]) begin
        win_found   = 1'b1;
        win_idx     = IW'(idx);
        win_oh[idx] = 1'b1;
        win_data    = din[idx*W +: W];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    win_id_d  = win_id_q;
    gnt_d     = '0;
    busy_d    = 1'b0;
    y_d       = y_q;
    y_valid_d = 1'b0;
    y_id_d    = y_id_q;
    gnt_cnt_d = gnt_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = EXEC;
          busy_d    = 1'b1;
          gnt_d     = win_oh;
          data_d    = win_data;
          win_id_d  = win_idx;
          ptr_d     = (32'(win_idx) == N - 1) ? '0 : win_idx + IW'(1);
          gnt_cnt_d = gnt_cnt_q + CW'(1);
        end
      end
      EXEC: begin
        // Requests seen here are ignored; they are re-evaluated on the next IDLE edge.
        state_d   = IDLE;
        y_d       = ~data_q;
        y_valid_d = 1'b1;
        y_id_d    = win_id_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      data_q    <= '0;
      win_id_q  <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_id_q    <= '0;
      gnt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      win_id_q  <= win_id_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_id_q    <= y_id_d;
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_id    = y_id_q;
  assign gnt_cnt = gnt_cnt_q;

endmodule
